// File: rtl/pmem_arbiter.sv
// N-channel arbiter between cache miss ports and a single physical memory port.
// One transaction at a time; round-robin or fixed-priority selection, internal latching and response routing.
module pmem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 16,
  parameter int RR_MODE = 1,
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          req_read,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_address,
  input  logic [NUM_CH*LINE_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          req_resp,
  output logic [LINE_W-1:0]          req_rdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  input  logic [LINE_W-1:0]          pmem_rdata,
  output logic [GW-1:0]              grant_id,
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [GW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]       grant_reg, grant_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LINE_W-1:0]   wdata_reg, wdata_next;
  logic                op_write_reg, op_write_next;

  logic [NUM_CH-1:0]   pend;
  logic [NUM_CH-1:0]   ge_mask, pend_hi, hi_first, lo_first, win_onehot;
  logic [GW-1:0]       start_ptr, win_idx;
  logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
  logic [LINE_W-1:0]   ch_wdata [NUM_CH];
  logic                in_busy, resp_fire;

  assign start_ptr = (RR_MODE != 0) ? rr_ptr_reg : '0;

  // Round-robin scan as two passes: channels at or above the pointer first, then wrap to the lowest.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign pend[gi]     = req_read[gi] | req_write[gi];
      assign ch_addr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
      assign ch_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
      assign ge_mask[gi]  = (GW'(gi) >= start_ptr);
      assign pend_hi[gi]  = pend[gi] & ge_mask[gi];
      if (gi == 0) begin : g_first
        assign hi_first[gi] = pend_hi[0];
        assign lo_first[gi] = pend[0];
      end else begin : g_rest
        assign hi_first[gi] = pend_hi[gi] & ~(|pend_hi[gi-1:0]);
        assign lo_first[gi] = pend[gi] & ~(|pend[gi-1:0]);
      end
      assign req_resp[gi] = resp_fire & (grant_reg == GW'(gi));
    end
  endgenerate

  assign win_onehot = (|pend_hi) ? hi_first : lo_first;

  generate
    for (genvar gj = 0; gj < GW; gj++) begin : g_enc
      logic [NUM_CH-1:0] bit_sel;
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bit
        assign bit_sel[gi] = win_onehot[gi] & 1'((gi >> gj) & 1);
      end
      assign win_idx[gj] = |bit_sel;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_next    = grant_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    op_write_next = op_write_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|pend) begin
          grant_next    = win_idx;
          addr_next     = ch_addr[win_idx];
          wdata_next    = ch_wdata[win_idx];
          op_write_next = req_write[win_idx];
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (pmem_resp) begin
          state_next = ST_RELEASE;
          if (RR_MODE != 0) begin
            rr_ptr_next = (grant_reg == GW'(NUM_CH - 1)) ? '0 : grant_reg + GW'(1);
          end
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      op_write_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_reg    <= grant_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      op_write_reg <= op_write_next;
    end
  end

  // Strobes and the response come from state, so an asynchronous reset clears them in the same cycle.
  assign in_busy      = (state_reg == ST_BUSY);
  assign resp_fire    = in_busy & pmem_resp;
  assign pmem_read    = in_busy & ~op_write_reg;
  assign pmem_write   = in_busy & op_write_reg;
  assign pmem_address = addr_reg;
  assign pmem_wdata   = wdata_reg;
  assign req_rdata    = pmem_rdata;
  assign grant_id     = grant_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomised scoreboard bench for pmem_arbiter: three builds (2ch RR, 2ch fixed, 4ch RR) run side by side
// against a transaction-level arbitration model.
module tb_pmem_arbiter;
  localparam int NDUT  = 3;
  localparam int MAXCH = 4;
  localparam int AW    = 16;
  localparam int LW    = 128;

  function automatic int nch(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic bit rrm(input int d);
    return (d != 1);
  endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [MAXCH-1:0]    rd [NDUT];
  logic [MAXCH-1:0]    wr [NDUT];
  logic [AW-1:0]       ad [NDUT][MAXCH];
  logic [LW-1:0]       wd [NDUT][MAXCH];
  logic [MAXCH*AW-1:0] ad_flat [NDUT];
  logic [MAXCH*LW-1:0] wd_flat [NDUT];
  logic                presp  [NDUT];
  logic [LW-1:0]       prdata [NDUT];

  logic                prd [NDUT];
  logic                pwr [NDUT];
  logic                bsy [NDUT];
  logic [AW-1:0]       paddr [NDUT];
  logic [LW-1:0]       pwd [NDUT];
  logic [LW-1:0]       rrd [NDUT];
  logic [1:0]          resp_0, resp_1;
  logic [3:0]          resp_2;
  logic                gid_0, gid_1;
  logic [1:0]          gid_2;
  logic [MAXCH-1:0]    resp [NDUT];
  logic [1:0]          gid [NDUT];

  assign resp[0] = {2'b00, resp_0};
  assign resp[1] = {2'b00, resp_1};
  assign resp[2] = resp_2;
  assign gid[0]  = {1'b0, gid_0};
  assign gid[1]  = {1'b0, gid_1};
  assign gid[2]  = gid_2;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_d
      for (genvar gj = 0; gj < MAXCH; gj++) begin : g_c
        assign ad_flat[gi][gj*AW +: AW] = ad[gi][gj];
        assign wd_flat[gi][gj*LW +: LW] = wd[gi][gj];
      end
    end
  endgenerate

  pmem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_read(rd[0][1:0]), .req_write(wr[0][1:0]),
    .req_address(ad_flat[0][2*AW-1:0]), .req_wdata(wd_flat[0][2*LW-1:0]),
    .req_resp(resp_0), .req_rdata(rrd[0]), .pmem_read(prd[0]), .pmem_write(pwr[0]),
    .pmem_address(paddr[0]), .pmem_wdata(pwd[0]), .pmem_resp(presp[0]), .pmem_rdata(prdata[0]),
    .grant_id(gid_0), .busy(bsy[0]));

  pmem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_read(rd[1][1:0]), .req_write(wr[1][1:0]),
    .req_address(ad_flat[1][2*AW-1:0]), .req_wdata(wd_flat[1][2*LW-1:0]),
    .req_resp(resp_1), .req_rdata(rrd[1]), .pmem_read(prd[1]), .pmem_write(pwr[1]),
    .pmem_address(paddr[1]), .pmem_wdata(pwd[1]), .pmem_resp(presp[1]), .pmem_rdata(prdata[1]),
    .grant_id(gid_1), .busy(bsy[1]));

  pmem_arbiter #(.NUM_CH(4), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_read(rd[2]), .req_write(wr[2]),
    .req_address(ad_flat[2]), .req_wdata(wd_flat[2]),
    .req_resp(resp_2), .req_rdata(rrd[2]), .pmem_read(prd[2]), .pmem_write(pwr[2]),
    .pmem_address(paddr[2]), .pmem_wdata(pwd[2]), .pmem_resp(presp[2]), .pmem_rdata(prdata[2]),
    .grant_id(gid_2), .busy(bsy[2]));

  typedef struct {
    int            ch;
    bit            w;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } gexp_t;

  typedef struct {
    int            ch;
    logic [LW-1:0] d;
  } rexp_t;

  gexp_t gq [NDUT][$];
  rexp_t rq [NDUT][$];

  int checks = 0;
  int errors = 0;

  // Model: 0 = free, 1 = serving, 2 = one dead cycle after completion.
  int m_st [NDUT];
  int m_rr [NDUT];
  int m_g  [NDUT];

  bit act  [NDUT][MAXCH];
  bit got  [NDUT][MAXCH];
  int cool [NDUT][MAXCH];
  bit armed [NDUT];
  int dly   [NDUT];
  bit en = 1'b0;
  bit hold = 1'b0;
  bit after_rst = 1'b0;
  int served [NDUT][MAXCH];
  int post_served [NDUT];

  task automatic chk(input string name, input int d, input logic [LW-1:0] act_v, input logic [LW-1:0] req_v);
    checks++;
    if (act_v !== req_v) begin
      errors++;
      $display("FAIL %s dut%0d actual %0h required %0h", name, d, act_v, req_v);
    end
  endtask

  // Reference model: transaction-level arbitration decision at each clock edge.
  int    md_n, md_w, md_c, md_start;
  logic [MAXCH-1:0] md_pend;
  gexp_t md_g;
  initial forever begin
    @(posedge clk or negedge reset_n);
    for (int d = 0; d < NDUT; d++) begin
      if (!reset_n) begin
        m_st[d] = 0; m_rr[d] = 0; m_g[d] = 0;
        gq[d].delete(); rq[d].delete();
      end else begin
        md_n = nch(d);
        case (m_st[d])
          0: begin
            md_pend = (rd[d] | wr[d]) & MAXCH'((1 << md_n) - 1);
            if (md_pend != 0) begin
              md_start = rrm(d) ? m_rr[d] : 0;
              md_w = -1;
              for (int k = 0; k < md_n; k++) begin
                md_c = (md_start + k) % md_n;
                if (md_w < 0 && md_pend[md_c]) md_w = md_c;
              end
              md_g.ch = md_w; md_g.w = wr[d][md_w]; md_g.a = ad[d][md_w]; md_g.d = wd[d][md_w];
              gq[d].push_back(md_g);
              m_g[d] = md_w;
              m_st[d] = 1;
            end
          end
          1: if (presp[d]) begin
            if (rrm(d)) m_rr[d] = (m_g[d] + 1) % md_n;
            m_st[d] = 2;
          end
          default: m_st[d] = 0;
        endcase
      end
    end
  end

  // Stimulus: requesters and memory responder, driven just after each rising edge.
  int    sk;
  rexp_t sr;
  initial forever begin
    @(posedge clk);
    #1;
    if (reset_n) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int c = 0; c < nch(d); c++) begin
          if (act[d][c] && got[d][c]) begin
            rd[d][c] = 1'b0; wr[d][c] = 1'b0;
            act[d][c] = 1'b0; got[d][c] = 1'b0;
            cool[d][c] = $urandom_range(0, 3);
          end else if (act[d][c]) begin
            if ($urandom % 4 == 0) ad[d][c] = AW'($urandom);
            if (m_st[d] == 1 && m_g[d] == c && $urandom % 8 == 0) begin
              rd[d][c] = 1'b0; wr[d][c] = 1'b0;
            end
          end else if (cool[d][c] > 0) begin
            cool[d][c]--;
          end else if (en && $urandom % 3 == 0) begin
            sk = $urandom % 3;
            rd[d][c] = (sk != 1);
            wr[d][c] = (sk != 0);
            ad[d][c] = AW'($urandom);
            wd[d][c] = {$urandom, $urandom, $urandom, $urandom};
            act[d][c] = 1'b1;
          end
        end
        if (presp[d]) begin
          presp[d] = 1'b0;
        end else if (m_st[d] == 1 && !hold) begin
          if (!armed[d]) begin
            armed[d] = 1'b1;
            dly[d] = $urandom_range(0, 4);
          end
          if (dly[d] == 0) begin
            presp[d] = 1'b1;
            prdata[d] = {$urandom, $urandom, $urandom, $urandom};
            sr.ch = m_g[d]; sr.d = prdata[d];
            rq[d].push_back(sr);
            got[d][m_g[d]] = 1'b1;
            armed[d] = 1'b0;
          end else begin
            dly[d]--;
          end
        end else if (m_st[d] != 1 && $urandom % 8 == 0) begin
          presp[d] = 1'b1;
          prdata[d] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // Monitor: pops expectations whenever a DUT starts a transaction or pulses req_resp.
  bit    prev [NDUT];
  gexp_t cur  [NDUT];
  gexp_t mg;
  rexp_t mr;
  logic  strobe;
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (!reset_n) begin
        prev[d] = 1'b0;
      end else begin
        strobe = prd[d] | pwr[d];
        chk("strobe", d, LW'(strobe), LW'(m_st[d] == 1));
        chk("busy", d, LW'(bsy[d]), LW'(m_st[d] != 0));
        if (strobe && !prev[d]) begin
          if (gq[d].size() == 0) begin
            chk("grant_expected", d, LW'(strobe), '0);
          end else begin
            mg = gq[d].pop_front();
            cur[d] = mg;
            $display("dut%0d grant ch%0d %s addr %h", d, mg.ch, mg.w ? "write" : "read", mg.a);
            chk("grant_id", d, LW'(gid[d]), LW'(mg.ch));
            chk("pmem_write", d, LW'(pwr[d]), LW'(mg.w));
            chk("pmem_read", d, LW'(prd[d]), LW'(!mg.w));
            chk("pmem_address", d, LW'(paddr[d]), LW'(mg.a));
            chk("pmem_wdata", d, pwd[d], mg.d);
            served[d][mg.ch]++;
            if (after_rst) post_served[d]++;
          end
        end else if (strobe) begin
          chk("addr_hold", d, LW'(paddr[d]), LW'(cur[d].a));
          chk("wdata_hold", d, pwd[d], cur[d].d);
        end
        if (resp[d] != 0 || rq[d].size() != 0) begin
          if (rq[d].size() == 0) begin
            chk("resp_spurious", d, LW'(resp[d]), '0);
          end else begin
            mr = rq[d].pop_front();
            chk("req_resp", d, LW'(resp[d]), LW'(1 << mr.ch));
            chk("req_rdata", d, rrd[d], mr.d);
          end
        end
        prev[d] = strobe;
      end
    end
  end

  bit all_busy;
  bit drained;
  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rd[d] = '0; wr[d] = '0; presp[d] = 1'b0; prdata[d] = '0;
      armed[d] = 1'b0; dly[d] = 0; prev[d] = 1'b0; post_served[d] = 0;
      for (int c = 0; c < MAXCH; c++) begin
        ad[d][c] = '0; wd[d][c] = '0;
        act[d][c] = 1'b0; got[d][c] = 1'b0; cool[d][c] = 0; served[d][c] = 0;
      end
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_read", d, LW'(prd[d]), '0);
      chk("rst_write", d, LW'(pwr[d]), '0);
      chk("rst_busy", d, LW'(bsy[d]), '0);
      chk("rst_resp", d, LW'(resp[d]), '0);
      chk("rst_grant", d, LW'(gid[d]), '0);
      chk("rst_addr", d, LW'(paddr[d]), '0);
      chk("rst_wdata", d, pwd[d], '0);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    en = 1'b1;
    repeat (1500) @(posedge clk);

    // Hold every DUT in a transaction, then reset with the memory response pending.
    hold = 1'b1;
    all_busy = 1'b0;
    for (int t = 0; t < 300 && !all_busy; t++) begin
      @(negedge clk);
      all_busy = (m_st[0] == 1) && (m_st[1] == 1) && (m_st[2] == 1);
    end
    chk("reach_busy", 0, LW'(all_busy), LW'(1));
    @(posedge clk); #2;
    reset_n = 1'b0;
    en = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      presp[d] = 1'b1;
      rd[d] = '0; wr[d] = '0; armed[d] = 1'b0;
      for (int c = 0; c < MAXCH; c++) begin
        act[d][c] = 1'b0; got[d][c] = 1'b0; cool[d][c] = 0;
      end
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("midrst_read", d, LW'(prd[d]), '0);
      chk("midrst_write", d, LW'(pwr[d]), '0);
      chk("midrst_busy", d, LW'(bsy[d]), '0);
      chk("midrst_resp", d, LW'(resp[d]), '0);
      chk("midrst_grant", d, LW'(gid[d]), '0);
    end
    repeat (2) begin
      @(posedge clk); #2;
      for (int d = 0; d < NDUT; d++) presp[d] = 1'b1;
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk("stale_resp", d, LW'(resp[d]), '0);
    repeat (5) @(posedge clk);
    after_rst = 1'b1;
    hold = 1'b0;
    en = 1'b1;
    repeat (1000) @(posedge clk);

    en = 1'b0;
    drained = 1'b0;
    for (int t = 0; t < 300 && !drained; t++) begin
      @(negedge clk);
      drained = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        if (m_st[d] != 0 || gq[d].size() != 0 || rq[d].size() != 0) drained = 1'b0;
        for (int c = 0; c < MAXCH; c++) if (act[d][c]) drained = 1'b0;
      end
    end
    chk("drained", 0, LW'(drained), LW'(1));
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < nch(d); c++) chk("ch_served", d, LW'(served[d][c] > 0), LW'(1));
      chk("post_rst_served", d, LW'(post_served[d] > 0), LW'(1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
